rxpybitpack: RTL and testbench

- Receive-side payload packer. Takes decoded payload bits serially from the link-controller decoder and packs them LSB-first into 32-bit words.
- Writes each word into the RX payload buffers through the rxlnctrl_addr / rxlnctrl_din / rxlnctrl_we port. This is the writer whose words the RX ACL/SCO buffer controllers later serve to the bus-side reader.
- At payload end it flushes any partial word, checks the received length, and reports completion or abort.

---
 rtl/rxpybitpack.sv | 143 ++++++++++++++
 tb/tb_rxpybitpack.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rxpybitpack.sv
// Receive payload packer: serial decoded payload bits -> LSB-first 32-bit words written to the RX buffer.
// Latency: a full word is written 1 cycle after its 32nd bit; a partial word is flushed 1 cycle after the FSM leaves PACK.
// Backpressure: none; the decoder strobes at most one bit per cycle and every accepted bit is absorbed without stalling.
//
// Ports:
//   clk_6M, rst              : clock and synchronous active-high reset
//   dec_py_period            : payload window; a new payload starts on its rising level while idle
//   dec_pybit_valid/dec_pybit: one payload bit per strobe
//   dec_py_endp              : last-bit marker, also samples dec_pylenByte (header length in bytes)
//   rxlnctrl_addr/din/we     : one-cycle word write into the RX payload buffer
//   rxpy_bitcount            : bits accepted so far (saturates at 8191)
//   rxpy_done_p/rxpy_abort_p : completion / window-closed-early pulses
//   rxpy_lenerr/rxpy_ovf     : held status of the last payload
module rxpybitpack #(
    parameter int MAXBITS = 8192
) (
    input  logic        clk_6M,
    input  logic        rst,
    input  logic        dec_py_period,
    input  logic        dec_pybit_valid,
    input  logic        dec_pybit,
    input  logic        dec_py_endp,
    input  logic [9:0]  dec_pylenByte,
    output logic [7:0]  rxlnctrl_addr,
    output logic [31:0] rxlnctrl_din,
    output logic        rxlnctrl_we,
    output logic [12:0] rxpy_bitcount,
    output logic        rxpy_done_p,
    output logic        rxpy_lenerr,
    output logic        rxpy_ovf,
    output logic        rxpy_abort_p
);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

    localparam logic [13:0] MAXCNT = 14'(MAXBITS);

    state_t      state;
    logic [13:0] cnt;       // one bit wider than the port so MAXBITS itself is representable
    logic [31:0] word;
    logic [9:0]  len_q;
    logic        wait_low;  // set after a completed payload: the window must close before the next one

    logic        accept;
    logic        word_full;
    logic [13:0] cnt_nxt;
    logic [31:0] word_nxt;

    assign accept    = dec_pybit_valid && (cnt < MAXCNT);
    assign word_full = accept && (cnt[4:0] == 5'd31);
    assign cnt_nxt   = accept ? cnt + 14'd1 : cnt;

    always_comb begin
        word_nxt = word;
        if (accept) begin
            word_nxt[cnt[4:0]] = dec_pybit;
        end
    end

    // A full 8192-bit payload reads back as 8191 on the 13-bit status port.
    assign rxpy_bitcount = (cnt > 14'h1FFF) ? 13'h1FFF : cnt[12:0];

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            word          <= '0;
            len_q         <= '0;
            wait_low      <= 1'b0;
            rxlnctrl_addr <= '0;
            rxlnctrl_din  <= '0;
            rxlnctrl_we   <= 1'b0;
            rxpy_done_p   <= 1'b0;
            rxpy_lenerr   <= 1'b0;
            rxpy_ovf      <= 1'b0;
            rxpy_abort_p  <= 1'b0;
        end else begin
            rxlnctrl_we  <= 1'b0;
            rxpy_done_p  <= 1'b0;
            rxpy_abort_p <= 1'b0;

            case (state)
                IDLE: begin
                    if (!dec_py_period) begin
                        wait_low <= 1'b0;
                    end else if (!wait_low) begin
                        cnt         <= '0;
                        word        <= '0;
                        rxpy_lenerr <= 1'b0;
                        rxpy_ovf    <= 1'b0;
                        state       <= PACK;
                    end
                end

                PACK: begin
                    // The end marker wins over a closing window: the payload completes normally.
                    if (dec_py_endp || dec_py_period) begin
                        cnt <= cnt_nxt;
                        if (dec_pybit_valid && !accept) begin
                            rxpy_ovf <= 1'b1;
                        end
                        if (word_full) begin
                            rxlnctrl_we   <= 1'b1;
                            rxlnctrl_addr <= cnt[12:5];
                            rxlnctrl_din  <= word_nxt;
                            word          <= '0;
                        end else begin
                            word <= word_nxt;
                        end
                    end

                    if (dec_py_endp) begin
                        len_q <= dec_pylenByte;
                        state <= (cnt_nxt[4:0] != 5'd0) ? FLUSH : DONE;
                    end else if (!dec_py_period) begin
                        rxpy_abort_p <= 1'b1;
                        word         <= '0;
                        state        <= IDLE;
                    end
                end

                FLUSH: begin
                    // Unwritten upper bits are already zero because word clears after every write.
                    rxlnctrl_we   <= 1'b1;
                    rxlnctrl_addr <= cnt[12:5];
                    rxlnctrl_din  <= word;
                    word          <= '0;
                    state         <= DONE;
                end

                DONE: begin
                    rxpy_done_p <= 1'b1;
                    rxpy_lenerr <= (cnt != {1'b0, len_q, 3'b000});
                    wait_low    <= 1'b1;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rxpybitpack.sv
// Bench for rxpybitpack: directed payloads, expected writes/completions/aborts queued by stimulus,
// popped and compared by an independent monitor on the falling clock edge.
module tb_rxpybitpack;

    logic        clk_6M = 1'b0;
    logic        rst;
    logic        dec_py_period;
    logic        dec_pybit_valid;
    logic        dec_pybit;
    logic        dec_py_endp;
    logic [9:0]  dec_pylenByte;
    logic [7:0]  rxlnctrl_addr;
    logic [31:0] rxlnctrl_din;
    logic        rxlnctrl_we;
    logic [12:0] rxpy_bitcount;
    logic        rxpy_done_p;
    logic        rxpy_lenerr;
    logic        rxpy_ovf;
    logic        rxpy_abort_p;

    rxpybitpack #(.MAXBITS(8192)) dut (
        .clk_6M          (clk_6M),
        .rst             (rst),
        .dec_py_period   (dec_py_period),
        .dec_pybit_valid (dec_pybit_valid),
        .dec_pybit       (dec_pybit),
        .dec_py_endp     (dec_py_endp),
        .dec_pylenByte   (dec_pylenByte),
        .rxlnctrl_addr   (rxlnctrl_addr),
        .rxlnctrl_din    (rxlnctrl_din),
        .rxlnctrl_we     (rxlnctrl_we),
        .rxpy_bitcount   (rxpy_bitcount),
        .rxpy_done_p     (rxpy_done_p),
        .rxpy_lenerr     (rxpy_lenerr),
        .rxpy_ovf        (rxpy_ovf),
        .rxpy_abort_p    (rxpy_abort_p)
    );

    always #5 clk_6M = ~clk_6M;

    int cyc = 0;
    always @(posedge clk_6M) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] din;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [12:0] bc;
        logic        lenerr;
        logic        ovf;
    } dn_t;

    wr_t  wq[$];
    dn_t  dq[$];
    int   aq[$];
    logic bits [0:8199];

    // Monitor: every DUT output event must match the oldest queued expectation.
    always @(negedge clk_6M) begin
        wr_t ew;
        dn_t ed;
        if (rxlnctrl_we) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr=%0d din=%h cyc=%0d", rxlnctrl_addr, rxlnctrl_din, cyc);
            end else begin
                ew = wq.pop_front();
                if (rxlnctrl_addr !== ew.addr || rxlnctrl_din !== ew.din || cyc != ew.cyc) begin
                    errors++;
                    $display("FAIL write got addr=%0d din=%h cyc=%0d want addr=%0d din=%h cyc=%0d",
                             rxlnctrl_addr, rxlnctrl_din, cyc, ew.addr, ew.din, ew.cyc);
                end
            end
        end
        if (rxpy_done_p) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d", cyc);
            end else begin
                ed = dq.pop_front();
                if (rxpy_bitcount !== ed.bc || rxpy_lenerr !== ed.lenerr || rxpy_ovf !== ed.ovf) begin
                    errors++;
                    $display("FAIL done got bc=%0d lenerr=%b ovf=%b want bc=%0d lenerr=%b ovf=%b",
                             rxpy_bitcount, rxpy_lenerr, rxpy_ovf, ed.bc, ed.lenerr, ed.ovf);
                end
            end
        end
        if (rxpy_abort_p) begin
            checks++;
            if (aq.size() == 0) begin
                errors++;
                $display("FAIL abort_unexpected cyc=%0d", cyc);
            end else begin
                void'(aq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_writes_pending"}, 32'(wq.size()), 32'd0);
        chk({name, "_done_pending"}, 32'(dq.size()), 32'd0);
        chk({name, "_abort_pending"}, 32'(aq.size()), 32'd0);
    endtask

    task automatic idle_inputs();
        dec_pybit_valid = 1'b0;
        dec_pybit       = 1'b0;
        dec_py_endp     = 1'b0;
    endtask

    // Sends bits[0..nbits-1] with endp on the last bit, queues the expected writes and completion.
    task automatic run_payload(input string name, input int nbits, input int lenb,
                               input logic [12:0] ebc, input logic elen, input logic eovf);
        logic [31:0] w;
        int          acc;
        w   = '0;
        acc = 0;
        dq.push_back(dn_t'{ebc, elen, eovf});
        dec_pylenByte = 10'(lenb);
        dec_py_period = 1'b1;
        tick();
        if (nbits == 0) begin
            dec_py_endp = 1'b1;
            tick();
        end
        for (int i = 0; i < nbits; i++) begin
            dec_pybit_valid = 1'b1;
            dec_pybit       = bits[i];
            dec_py_endp     = (i == nbits - 1);
            if (acc < 8192) begin
                w[acc % 32] = bits[i];
                if (acc % 32 == 31) begin
                    wq.push_back(wr_t'{8'(acc / 32), w, cyc + 1});
                    w = '0;
                end
                acc++;
            end
            if (i == nbits - 1 && acc % 32 != 0) begin
                wq.push_back(wr_t'{8'(acc / 32), w, cyc + 2});
            end
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        dec_py_period = 1'b0;
        repeat (2) tick();
        chk_drained(name);
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] w1;

        rst           = 1'b1;
        dec_py_period = 1'b0;
        dec_pylenByte = '0;
        idle_inputs();
        repeat (2) tick();
        chk("reset_addr", 32'(rxlnctrl_addr), 32'd0);
        chk("reset_din", rxlnctrl_din, 32'd0);
        chk("reset_flags", 32'({rxlnctrl_we, rxpy_done_p, rxpy_lenerr, rxpy_ovf, rxpy_abort_p, rxpy_bitcount}), 32'd0);
        rst = 1'b0;
        tick();

        // 1: two full words, no flush
        w0 = 32'hA5A5A5A5;
        w1 = 32'h12345678;
        for (int i = 0; i < 64; i++) bits[i] = (i < 32) ? w0[i] : w1[i - 32];
        wq.push_back(wr_t'{8'd0, 32'hA5A5A5A5, -1});
        void'(wq.pop_back());
        run_payload("t1_64bits", 64, 8, 13'd64, 1'b0, 1'b0);
        chk("t1_bitcount_held", 32'(rxpy_bitcount), 32'd64);

        // 2: 40 ones, flush of the 8-bit tail
        for (int i = 0; i < 40; i++) bits[i] = 1'b1;
        run_payload("t2_40bits", 40, 5, 13'd40, 1'b0, 1'b0);

        // 3: same bits, header claims 6 bytes
        run_payload("t3_lenerr", 40, 6, 13'd40, 1'b1, 1'b0);
        repeat (3) tick();
        chk("t3_lenerr_held", 32'(rxpy_lenerr), 32'd1);

        // 4: window closes after 20 bits without endp
        dec_py_period = 1'b1;
        tick();
        chk("t4_lenerr_cleared", 32'(rxpy_lenerr), 32'd0);
        chk("t4_bitcount_cleared", 32'(rxpy_bitcount), 32'd0);
        for (int i = 0; i < 20; i++) begin
            dec_pybit_valid = 1'b1;
            dec_pybit       = 1'(i % 3);
            tick();
        end
        idle_inputs();
        chk("t4_bitcount_20", 32'(rxpy_bitcount), 32'd20);
        aq.push_back(1);
        dec_py_period = 1'b0;
        repeat (4) tick();
        chk_drained("t4_abort");
        w0 = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) bits[i] = w0[i];
        run_payload("t4_after_abort", 32, 4, 13'd32, 1'b0, 1'b0);

        // 5: 8200 bits offered, only 8192 kept
        for (int i = 0; i < 8200; i++) bits[i] = ((i * 7) % 3) == 0;
        run_payload("t5_overflow", 8200, 1023, 13'h1FFF, 1'b1, 1'b1);
        chk("t5_ovf_held", 32'(rxpy_ovf), 32'd1);
        chk("t5_bitcount_sat", 32'(rxpy_bitcount), 32'h1FFF);

        // 6: reset 10 bits into a payload
        dec_py_period = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            dec_pybit_valid = 1'b1;
            dec_pybit       = 1'b1;
            tick();
        end
        idle_inputs();
        rst           = 1'b1;
        dec_py_period = 1'b0;
        tick();
        chk("t6_rst_addr", 32'(rxlnctrl_addr), 32'd0);
        chk("t6_rst_din", rxlnctrl_din, 32'd0);
        chk("t6_rst_flags", 32'({rxlnctrl_we, rxpy_done_p, rxpy_lenerr, rxpy_ovf, rxpy_abort_p, rxpy_bitcount}), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk_drained("t6_rst");
        w0 = 32'h0F0F3C3C;
        for (int i = 0; i < 32; i++) bits[i] = w0[i];
        run_payload("t6_after_rst", 32, 4, 13'd32, 1'b0, 1'b0);

        // 7: zero-length payload
        run_payload("t7_zero_len", 0, 0, 13'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
